// File: rtl/writeback_stage.sv
// Final pipeline stage: commits one instruction per cycle to the register file, bypass and retire port.
// Optional retired-instruction counter is built when WB_RETIRE_COUNTER_EN is defined.
module writeback_stage #(
    localparam int ADDR_WIDTH              = 32,
    localparam int DATA_WIDTH              = 32,
    localparam int REGISTER_INDEXING_WIDTH = $clog2(32)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               prev_done,
    output logic                               stall_prev,
    input  logic [ADDR_WIDTH-1:0]              program_count_in,
    input  logic                               program_count_valid_in,
    input  logic                               environment_in,
    input  logic                               opcode_legal_in,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register_in,
    input  logic                               write_register_valid_in,
    input  logic [DATA_WIDTH-1:0]              result_data_in,
    input  logic                               result_data_valid_in,
    output logic                               reg_write_en,
    output logic [REGISTER_INDEXING_WIDTH-1:0] reg_write_index,
    output logic [DATA_WIDTH-1:0]              reg_write_data,
    output logic                               bypass_valid,
    output logic [REGISTER_INDEXING_WIDTH-1:0] bypass_index,
    output logic [DATA_WIDTH-1:0]              bypass_data,
    output logic                               retire_pulse,
    output logic [ADDR_WIDTH-1:0]              retire_pc,
    output logic                               trap,
    output logic [1:0]                         trap_cause,
    output logic [ADDR_WIDTH-1:0]              trap_pc,
    output logic [1:0]                         state_dbg
`ifdef WB_RETIRE_COUNTER_EN
    ,
    output logic [63:0]                        retire_count
`endif
);

    // Handshake: a transfer happens on a rising edge where prev_done is high and
    // stall_prev is low; the stage then holds that instruction for exactly one cycle.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                             state;
    logic [ADDR_WIDTH-1:0]              pc_q;
    logic                               env_q;
    logic                               legal_q;
    logic [REGISTER_INDEXING_WIDTH-1:0] idx_q;
    logic                               idx_valid_q;
    logic [DATA_WIDTH-1:0]              data_q;
    logic                               data_valid_q;

    logic       trap_now;
    logic [1:0] trap_code;
    logic       commit;
    logic       transfer_prev;
    logic       unused_pc_valid;

    assign unused_pc_valid = program_count_valid_in;

    always_comb begin
        trap_now  = 1'b0;
        trap_code = 2'd0;
        if (state == HOLD) begin
            if (!legal_q) begin
                trap_now  = 1'b1;
                trap_code = 2'd0;
            end else if (env_q) begin
                trap_now  = 1'b1;
                trap_code = 2'd1;
            end else if (idx_valid_q && idx_q != '0 && !data_valid_q) begin
                trap_now  = 1'b1;
                trap_code = 2'd2;
            end
        end
    end

    assign commit        = (state == HOLD) && !trap_now;
    assign stall_prev    = !rst_n || (state == HALTED) || ((state == HOLD) && trap_now);
    assign transfer_prev = prev_done && !stall_prev;

    // x0 destinations retire without writing.
    assign reg_write_en    = commit && idx_valid_q && (idx_q != '0);
    assign reg_write_index = commit ? idx_q : '0;
    assign reg_write_data  = commit ? data_q : '0;
    assign bypass_valid    = reg_write_en;
    assign bypass_index    = reg_write_index;
    assign bypass_data     = reg_write_data;
    assign retire_pulse    = commit;
    assign retire_pc       = commit ? pc_q : '0;
    assign state_dbg       = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            pc_q         <= '0;
            env_q        <= 1'b0;
            legal_q      <= 1'b0;
            idx_q        <= '0;
            idx_valid_q  <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            trap         <= 1'b0;
            trap_cause   <= 2'd0;
            trap_pc      <= '0;
        end else begin
            case (state)
                HALTED: state <= HALTED;
                default: begin
                    if (trap_now) begin
                        state      <= HALTED;
                        trap       <= 1'b1;
                        trap_cause <= trap_code;
                        trap_pc    <= pc_q;
                    end else if (transfer_prev) begin
                        state        <= HOLD;
                        pc_q         <= program_count_in;
                        env_q        <= environment_in;
                        legal_q      <= opcode_legal_in;
                        idx_q        <= write_register_in;
                        idx_valid_q  <= write_register_valid_in;
                        data_q       <= result_data_in;
                        data_valid_q <= result_data_valid_in;
                    end else begin
                        state <= EMPTY;
                    end
                end
            endcase
        end
    end

`ifdef WB_RETIRE_COUNTER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count <= '0;
        end else if (retire_pulse) begin
            retire_count <= retire_count + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: commit scoreboard plus per-scenario directed checks.
module tb_writeback_stage;
    localparam int EW = 70;

    logic        clk;
    logic        rst_n;
    logic        prev_done;
    logic        stall_prev;
    logic [31:0] program_count_in;
    logic        program_count_valid_in;
    logic        environment_in;
    logic        opcode_legal_in;
    logic [4:0]  write_register_in;
    logic        write_register_valid_in;
    logic [31:0] result_data_in;
    logic        result_data_valid_in;
    logic        reg_write_en;
    logic [4:0]  reg_write_index;
    logic [31:0] reg_write_data;
    logic        bypass_valid;
    logic [4:0]  bypass_index;
    logic [31:0] bypass_data;
    logic        retire_pulse;
    logic [31:0] retire_pc;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] trap_pc;
    logic [1:0]  state_dbg;
`ifdef WB_RETIRE_COUNTER_EN
    logic [63:0] retire_count;
`endif

    int total = 0;
    int bad = 0;
    longint exp_retired = 0;
    logic [EW-1:0] exp_q[$];

    writeback_stage dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .prev_done              (prev_done),
        .stall_prev             (stall_prev),
        .program_count_in       (program_count_in),
        .program_count_valid_in (program_count_valid_in),
        .environment_in         (environment_in),
        .opcode_legal_in        (opcode_legal_in),
        .write_register_in      (write_register_in),
        .write_register_valid_in(write_register_valid_in),
        .result_data_in         (result_data_in),
        .result_data_valid_in   (result_data_valid_in),
        .reg_write_en           (reg_write_en),
        .reg_write_index        (reg_write_index),
        .reg_write_data         (reg_write_data),
        .bypass_valid           (bypass_valid),
        .bypass_index           (bypass_index),
        .bypass_data            (bypass_data),
        .retire_pulse           (retire_pulse),
        .retire_pc              (retire_pc),
        .trap                   (trap),
        .trap_cause             (trap_cause),
        .trap_pc                (trap_pc),
        .state_dbg              (state_dbg)
`ifdef WB_RETIRE_COUNTER_EN
        ,
        .retire_count           (retire_count)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: every commit seen on a falling edge must match the oldest expected entry
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_n) begin
            if (retire_pulse) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL commit_unexpected pc=%h expected no commit", retire_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (retire_pc !== e[31:0] || reg_write_en !== e[69] || bypass_valid !== e[69]) begin
                        bad++;
                        $display("FAIL commit_ctrl got pc=%h we=%b bv=%b want pc=%h we=%b",
                                 retire_pc, reg_write_en, bypass_valid, e[31:0], e[69]);
                    end else if (e[69] && (reg_write_index !== e[68:64] || reg_write_data !== e[63:32] ||
                                           bypass_index !== e[68:64] || bypass_data !== e[63:32])) begin
                        bad++;
                        $display("FAIL commit_data got idx=%0d data=%h bidx=%0d bdata=%h want idx=%0d data=%h",
                                 reg_write_index, reg_write_data, bypass_index, bypass_data, e[68:64], e[63:32]);
                    end
                end
            end else if (reg_write_en || bypass_valid) begin
                total++;
                bad++;
                $display("FAIL write_without_retire got we=%b bv=%b want 0", reg_write_en, bypass_valid);
            end
        end
    end

    // driver tasks
    task automatic set_instr(input logic [31:0] pc, input logic env, input logic legal,
                             input logic [4:0] idx, input logic idx_v,
                             input logic [31:0] data, input logic data_v);
        prev_done               = 1'b1;
        program_count_in        = pc;
        program_count_valid_in  = 1'b1;
        environment_in          = env;
        opcode_legal_in         = legal;
        write_register_in       = idx;
        write_register_valid_in = idx_v;
        result_data_in          = data;
        result_data_valid_in    = data_v;
    endtask

    task automatic push_exp(input logic we, input logic [4:0] idx, input logic [31:0] data,
                            input logic [31:0] pc);
        exp_q.push_back({we, idx, data, pc});
        exp_retired++;
    endtask

    task automatic idle();
        prev_done = 1'b0;
        program_count_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_retired = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string name);
`ifdef WB_RETIRE_COUNTER_EN
        total++;
        if (retire_count !== 64'(exp_retired)) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, retire_count, exp_retired);
        end
`else
        if (name.len() == 0) $display("empty count name");
`endif
    endtask

    // scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        set_instr(32'h0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0, 1'b0);
        idle();
        @(negedge clk);
        total++;
        if (stall_prev !== 1'b1 || reg_write_en !== 1'b0 || bypass_valid !== 1'b0 ||
            retire_pulse !== 1'b0 || retire_pc !== 32'h0 || trap !== 1'b0 ||
            trap_cause !== 2'd0 || trap_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_values got stall=%b we=%b bv=%b rp=%b trap=%b cause=%0d tpc=%h want 1,0,0,0,0,0,0",
                     stall_prev, reg_write_en, bypass_valid, retire_pulse, trap, trap_cause, trap_pc);
        end
        check_count("reset_count");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (stall_prev !== 1'b0) begin
            bad++;
            $display("FAIL ready_after_reset got stall=%b want 0", stall_prev);
        end
    endtask

    task automatic test_single();
        set_instr(32'h40, 1'b0, 1'b1, 5'd5, 1'b1, 32'h1234_5678, 1'b1);
        push_exp(1'b1, 5'd5, 32'h1234_5678, 32'h40);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        total++;
        if (reg_write_en !== 1'b1 || reg_write_index !== 5'd5 || reg_write_data !== 32'h1234_5678 ||
            bypass_valid !== 1'b1 || bypass_index !== 5'd5 || bypass_data !== 32'h1234_5678 ||
            retire_pulse !== 1'b1) begin
            bad++;
            $display("FAIL single_commit got we=%b idx=%0d data=%h bv=%b bidx=%0d bdata=%h rp=%b want 1,5,12345678,1,5,12345678,1",
                     reg_write_en, reg_write_index, reg_write_data, bypass_valid, bypass_index, bypass_data, retire_pulse);
        end
        @(negedge clk);
        total++;
        if (retire_pulse !== 1'b0 || reg_write_en !== 1'b0) begin
            bad++;
            $display("FAIL single_pulse_width got rp=%b we=%b want 0,0", retire_pulse, reg_write_en);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            set_instr(32'h200 + 32'(4 * i), 1'b0, 1'b1, 5'(i), 1'b1, 32'(i), 1'b1);
            push_exp(1'b1, 5'(i), 32'(i), 32'h200 + 32'(4 * i));
            @(negedge clk);
            total++;
            if (stall_prev !== 1'b0) begin
                bad++;
                $display("FAIL b2b_stall i=%0d got=%b want 0", i, stall_prev);
            end
            if (i > 1) begin
                total++;
                if (retire_pulse !== 1'b1 || reg_write_index !== 5'(i - 1)) begin
                    bad++;
                    $display("FAIL b2b_bubble i=%0d got rp=%b idx=%0d want 1,%0d", i, retire_pulse, reg_write_index, i - 1);
                end
            end
            @(posedge clk);
            #1;
        end
        idle();
        @(negedge clk);
        total++;
        if (retire_pulse !== 1'b1 || reg_write_index !== 5'd4) begin
            bad++;
            $display("FAIL b2b_last got rp=%b idx=%0d want 1,4", retire_pulse, reg_write_index);
        end
        @(negedge clk);
        check_count("b2b_count");
        @(posedge clk);
        #1;
    endtask

    task automatic test_x0();
        set_instr(32'h300, 1'b0, 1'b1, 5'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        push_exp(1'b0, 5'd0, 32'hFFFF_FFFF, 32'h300);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        total++;
        if (reg_write_en !== 1'b0 || retire_pulse !== 1'b1 || retire_pc !== 32'h300) begin
            bad++;
            $display("FAIL x0_write got we=%b rp=%b pc=%h want 0,1,300", reg_write_en, retire_pulse, retire_pc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_trap_illegal();
        set_instr(32'h100, 1'b0, 1'b0, 5'd3, 1'b1, 32'hAA, 1'b1);
        @(posedge clk);
        #1;
        set_instr(32'h104, 1'b0, 1'b1, 5'd6, 1'b1, 32'h55, 1'b1);
        @(negedge clk);
        total++;
        if (stall_prev !== 1'b1 || reg_write_en !== 1'b0 || retire_pulse !== 1'b0) begin
            bad++;
            $display("FAIL trap_hold got stall=%b we=%b rp=%b want 1,0,0", stall_prev, reg_write_en, retire_pulse);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            total++;
            if (stall_prev !== 1'b1 || trap !== 1'b1 || trap_cause !== 2'd0 ||
                trap_pc !== 32'h100 || retire_pulse !== 1'b0) begin
                bad++;
                $display("FAIL trap_halted k=%0d got stall=%b trap=%b cause=%0d pc=%h rp=%b want 1,1,0,100,0",
                         k, stall_prev, trap, trap_cause, trap_pc, retire_pulse);
            end
        end
        check_count("trap_count");
        idle();
    endtask

    task automatic test_reset_halted();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_retired = 0;
        #1;
        total++;
        if (trap !== 1'b0 || trap_cause !== 2'd0 || trap_pc !== 32'h0 || stall_prev !== 1'b1 ||
            retire_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_halted got trap=%b cause=%0d pc=%h stall=%b rp=%b want 0,0,0,1,0",
                     trap, trap_cause, trap_pc, stall_prev, retire_pulse);
        end
        check_count("reset_halted_count");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_trap_cause(input logic env, input logic data_v, input logic [31:0] pc,
                                   input logic [1:0] cause);
        set_instr(pc, env, 1'b1, 5'd7, 1'b1, 32'hDEAD, data_v);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        total++;
        if (retire_pulse !== 1'b0 || stall_prev !== 1'b1) begin
            bad++;
            $display("FAIL trap%0d_hold got rp=%b stall=%b want 0,1", cause, retire_pulse, stall_prev);
        end
        @(negedge clk);
        total++;
        if (trap !== 1'b1 || trap_cause !== cause || trap_pc !== pc) begin
            bad++;
            $display("FAIL trap%0d_latch got trap=%b cause=%0d pc=%h want 1,%0d,%h",
                     cause, trap, trap_cause, trap_pc, cause, pc);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        set_instr(32'h700, 1'b0, 1'b1, 5'd9, 1'b1, 32'h99, 1'b1);
        @(posedge clk);
        #1;
        idle();
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (reg_write_en !== 1'b0 || retire_pulse !== 1'b0 || bypass_valid !== 1'b0 || stall_prev !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid got we=%b rp=%b bv=%b stall=%b want 0,0,0,1",
                     reg_write_en, retire_pulse, bypass_valid, stall_prev);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_instr(32'h800, 1'b0, 1'b1, 5'd10, 1'b1, 32'hCAFE_F00D, 1'b1);
        push_exp(1'b1, 5'd10, 32'hCAFE_F00D, 32'h800);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        total++;
        if (reg_write_en !== 1'b1 || reg_write_index !== 5'd10 || reg_write_data !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL after_reset_commit got we=%b idx=%0d data=%h want 1,10,cafef00d",
                     reg_write_en, reg_write_index, reg_write_data);
        end
        @(negedge clk);
        check_count("after_reset_count");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_x0();
        test_trap_illegal();
        test_reset_halted();
        test_trap_cause(1'b0, 1'b0, 32'h500, 2'd2);
        test_trap_cause(1'b1, 1'b1, 32'h600, 2'd1);
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
